btn_debounce_pulse: RTL
=======================

// Module: btn_debounce_pulse
// PURPOSE
//   Conditions the raw board push-buttons that drive the ALU top's i_btn bus.
//   Buttons are load-A, load-B, load-OP and ALU reset.
//   Per channel: synchronises the asynchronous button, debounces it with a
//   stable-time counter, and outputs a clean level plus a one-cycle press pulse.
//   The ALU top consumes o_btn_pulse, so each physical press performs exactly one load.
// PARAMETERS
//   BTN_COUNT        4          number of independent button channels
//   DEBOUNCE_CYCLES  1_000_000  stable cycles required (10 ms @ 100 MHz); legal range >= 2
//   SYNC_STAGES      2          synchroniser flip-flop depth; legal range >= 2
// PORTS
//   i_clk        in   1          system clock, 100 MHz; all logic on the rising edge
//   i_rst_n      in   1          reset, synchronous, active-low
//   i_btn        in   BTN_COUNT  raw asynchronous buttons, active-high
//   o_btn_level  out  BTN_COUNT  debounced button level
//   o_btn_pulse  out  BTN_COUNT  one-cycle high on each debounced press
// BEHAVIOUR
//   Reset
//   - While i_rst_n=0 at a rising edge: clear all synchroniser stages, counters,
//     o_btn_level and o_btn_pulse to 0.
//   - Every channel FSM goes to S_LOW.
//   - Reset takes priority over every other event, including mid-count.
//   Channels
//   - Channels are fully independent; each has its own synchroniser, counter and FSM.
//   - Counter width is $clog2(DEBOUNCE_CYCLES).
//   - sync denotes the last synchroniser stage.
//   Per-channel FSM
//   - S_LOW:  if sync=1, go to S_RISE and set cnt=0.
//   - S_RISE:
//     - If sync=0, go to S_LOW and set cnt=0 (glitch rejected).
//     - Else if cnt==DEBOUNCE_CYCLES-1: go to S_HIGH, set o_btn_level=1 and o_btn_pulse=1.
//     - Else cnt++.
//   - S_HIGH: if sync=0, go to S_FALL and set cnt=0.
//   - S_FALL:
//     - If sync=1, go to S_HIGH and set cnt=0 (release bounce rejected).
//     - Else if cnt==DEBOUNCE_CYCLES-1: go to S_LOW and set o_btn_level=0. No pulse.
//     - Else cnt++.
//   Outputs
//   - o_btn_pulse is registered and high for exactly one cycle.
//   - o_btn_pulse is 0 in all cycles other than the S_RISE->S_HIGH transition.
//   - o_btn_level changes only on a completed S_RISE->S_HIGH or S_FALL->S_LOW transition.
//   Latency
//   - Define edge 0 as the first edge that samples i_btn=1, with i_btn held high.
//   - o_btn_level and o_btn_pulse are registered high at edge SYNC_STAGES+DEBOUNCE_CYCLES.
//   - o_btn_pulse returns to 0 at the next edge.
//   - Release is symmetric: o_btn_level falls at edge SYNC_STAGES+DEBOUNCE_CYCLES after
//     the first edge that samples i_btn=0.
//   Boundary conditions
//   - A high shorter than DEBOUNCE_CYCLES stable cycles produces no pulse and no level change.
//   - A button held continuously gives exactly one pulse. No auto-repeat.
//   - A counter never wraps: it is bounded at DEBOUNCE_CYCLES-1.
//   - A button held across reset deassertion is treated as a new press: full debounce,
//     then one pulse.
//   - Presses completing on the same edge on several channels pulse on the same cycle.
// TESTING (bench overrides DEBOUNCE_CYCLES=8, SYNC_STAGES=2)
//   1. Reset, then hold i_btn=4'b0000 for 20 cycles -> o_btn_level=0 and o_btn_pulse=0
//      on every cycle.
//   2. Sample i_btn[0]=1 first at edge 0 and hold it high -> o_btn_level[0]=1 and
//      o_btn_pulse[0]=1 at edge 10; pulse=0 at edge 11; no further pulses while held.
//   3. i_btn[1]=1 for 5 cycles, then 0 -> o_btn_pulse[1] and o_btn_level[1] stay 0 throughout.
//   4. Press i_btn[2] until o_btn_level[2]=1, then release with 3-cycle bounces (1/0/1/0),
//      then hold 0 -> o_btn_level[2] falls once, 10 edges after the final 0 is sampled;
//      no second pulse.
//   5. Raise i_btn[0] and i_btn[3] on the same edge -> o_btn_pulse=4'b1001 for exactly
//      one cycle at edge 10.
//   6. Hold i_btn[0]=1 and assert i_rst_n=0 at edge 6 of the count -> outputs 0 next cycle.
//      Release reset with the button still held -> a single pulse 10 edges after the first
//      post-reset sampling edge.

Source files
------------

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: per-channel synchroniser, stable-time debouncer and
// one-cycle press pulse generator feeding the ALU top's load/reset buttons.
module btn_debounce_pulse #(
   parameter int BTN_COUNT       = 4,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [BTN_COUNT-1:0] i_btn,
   output logic [BTN_COUNT-1:0] o_btn_level,
   output logic [BTN_COUNT-1:0] o_btn_pulse
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_LOW,
      S_RISE,
      S_HIGH,
      S_FALL
   } state_t;

   for (genvar g = 0; g < BTN_COUNT; g++) begin : g_chan
      logic [SYNC_STAGES-1:0] r_sync;
      logic [CNT_W-1:0]       r_cnt;
      state_t                 r_state;
      logic                   r_level;
      logic                   r_pulse;
      logic                   w_sync;

      assign w_sync         = r_sync[SYNC_STAGES-1];
      assign o_btn_level[g] = r_level;
      assign o_btn_pulse[g] = r_pulse;

      // Bit 0 is the metastability-exposed stage; only the last stage feeds the FSM.
      always_ff @(posedge i_clk) begin
         if (!i_rst_n) begin
            r_sync <= '0;
         end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn[g]};
         end
      end

      // Any return to the old level while counting restarts from the stable state,
      // so the counter stops at CNT_MAX and never wraps.
      always_ff @(posedge i_clk) begin
         if (!i_rst_n) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
         end else begin
            r_pulse <= 1'b0;
            case (r_state)
               S_LOW: begin
                  if (w_sync) begin
                     r_state <= S_RISE;
                     r_cnt   <= '0;
                  end
               end
               S_RISE: begin
                  if (!w_sync) begin
                     r_state <= S_LOW;
                     r_cnt   <= '0;
                  end else if (r_cnt == CNT_MAX) begin
                     r_state <= S_HIGH;
                     r_level <= 1'b1;
                     r_pulse <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               S_HIGH: begin
                  if (!w_sync) begin
                     r_state <= S_FALL;
                     r_cnt   <= '0;
                  end
               end
               S_FALL: begin
                  if (w_sync) begin
                     r_state <= S_HIGH;
                     r_cnt   <= '0;
                  end else if (r_cnt == CNT_MAX) begin
                     r_state <= S_LOW;
                     r_level <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               default: begin
                  r_state <= S_LOW;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule
